// File: rtl/pvt_readout_seq_if.sv
// pvt_readout_seq_if: valid/ready byte stream that carries readout frames out of the sequencer
interface pvt_readout_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/pvt_readout_seq.sv
// pvt_readout_seq: samples PVT monitors once per interval and streams a 6-byte summary frame per NSAMP samples
module pvt_readout_seq #(
  parameter int INTERVAL = 256,
  parameter int NSAMP    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               meas_cnt,
  input  logic [6:0]               skew_code,
  input  logic                     osc_div,
  pvt_readout_seq_if.master        tx,
  output logic                     busy,
  output logic                     overrun
);
  localparam int LG = $clog2(NSAMP);
  localparam int SW = 8 + LG;
  localparam logic [15:0] LAST = 16'(INTERVAL - 1);
  localparam logic [LG-1:0] IDX_LAST = LG'(NSAMP - 1);
  typedef enum logic [1:0] {IDLE, ACQ, SEND} state_t;
  state_t        state_q;
  logic [2:0]    sync_q;
  logic [15:0]   cnt_q;
  logic [7:0]    ecnt_q, tx_data_q;
  logic [SW-1:0] sum_q, sum_d;
  logic [6:0]    min_q, max_q, min_d, max_d;
  logic [LG-1:0] idx_q;
  logic [2:0]    bidx_q;
  logic [7:0]    frm_q [6];
  logic [7:0]    b1, b2, b3, b5;
  logic          rise, tc, done, tx_valid_q, overrun_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = state_q != IDLE;
  assign overrun     = overrun_q;
  always_comb begin
    rise  = sync_q[1] & ~sync_q[2];
    tc    = en && cnt_q == LAST;
    done  = tc && idx_q == IDX_LAST;
    sum_d = sum_q + SW'(meas_cnt);
    min_d = skew_code < min_q ? skew_code : min_q;
    max_d = skew_code > max_q ? skew_code : max_q;
    b1    = 8'(sum_d >> LG);
    b2    = {1'b0, min_d};
    b3    = {1'b0, max_d};
    b5    = b1 ^ b2 ^ b3 ^ ecnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      cnt_q      <= '0;
      ecnt_q     <= '0;
      sum_q      <= '0;
      min_q      <= 7'h7F;
      max_q      <= '0;
      idx_q      <= '0;
      bidx_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], osc_div};
      cnt_q  <= (tc || !en) ? '0 : cnt_q + 16'd1;
      // an edge landing on the sample cycle starts the next interval's count
      ecnt_q <= !en ? '0 : tc ? {7'd0, rise} : ecnt_q + {7'd0, rise && ecnt_q != 8'hFF};
      if (!en || done) begin
        sum_q <= '0;
        min_q <= 7'h7F;
        max_q <= '0;
        idx_q <= '0;
      end else if (tc) begin
        sum_q <= sum_d;
        min_q <= min_d;
        max_q <= max_d;
        idx_q <= idx_q + LG'(1);
      end
      case (state_q)
        IDLE: state_q <= en ? ACQ : IDLE;
        ACQ: begin
          if (!en) state_q <= IDLE;
          else if (done) begin
            state_q    <= SEND;
            frm_q      <= '{8'hA5, b1, b2, b3, ecnt_q, b5};
            bidx_q     <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= 8'hA5;
          end
        end
        SEND: begin
          if (done) overrun_q <= 1'b1;
          if (tx.tx_ready) begin
            if (bidx_q == 3'd5) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              state_q    <= en ? ACQ : IDLE;
            end else begin
              bidx_q    <= bidx_q + 3'd1;
              tx_data_q <= frm_q[bidx_q + 3'd1];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pvt_readout_seq.sv
// tb_pvt_readout_seq: scoreboard bench with a sample-list reference model for the readout sequencer
module tb_pvt_readout_seq;
  localparam int IV = 4;
  localparam int NS = 2;
  logic clk = 0, rst = 1, en = 0, osc = 0, en_b = 0, osc_b = 0;
  logic [7:0] meas = 0;
  logic [6:0] skew = 0;
  logic busy, ovr, busy_b, ovr_b;
  int tests = 0, fails = 0;
  bit chk_on = 0;
  logic [7:0] exp_q[$], exp_b[$], rx_q[$];
  int s_meas[$], s_skew[$];
  int m = 0, pend = 0;
  bit ovr_m = 0;
  pvt_readout_seq_if ifa();
  pvt_readout_seq_if ifb();
  pvt_readout_seq #(.INTERVAL(IV), .NSAMP(NS)) dut (
    .clk(clk), .rst(rst), .en(en), .meas_cnt(meas), .skew_code(skew), .osc_div(osc),
    .tx(ifa), .busy(busy), .overrun(ovr));
  pvt_readout_seq #(.INTERVAL(1024), .NSAMP(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .meas_cnt(8'd40), .skew_code(7'd3), .osc_div(osc_b),
    .tx(ifb), .busy(busy_b), .overrun(ovr_b));
  always #5 clk = ~clk;
  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int k = 0;
    while (pend > 0 && k < 300) begin
      cyc(1);
      k++;
    end
    check("drain_pending", pend, 0);
  endtask
  task automatic check_rx(string n, logic [47:0] e);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_b%0d", n, i), i < rx_q.size() ? rx_q[i] : 8'hxx, e[47-8*i -: 8]);
    rx_q.delete();
  endtask
  // reference model: keeps the samples of the frame under construction and the bytes still owed
  always @(posedge clk) begin : model
    int p, sum, mn, mx, b1, b5;
    if (rst) begin
      m = 0; pend = 0; ovr_m = 0;
      s_meas.delete(); s_skew.delete(); exp_q.delete();
    end else begin
      p = pend;
      if (p > 0 && ifa.tx_ready) pend--;
      if (!en) begin
        m = 0;
        s_meas.delete(); s_skew.delete();
      end else begin
        m++;
        if (m % IV == 0) begin
          s_meas.push_back(int'(meas));
          s_skew.push_back(int'(skew));
          if (s_meas.size() == NS) begin
            sum = 0; mn = 127; mx = 0;
            foreach (s_meas[i]) begin
              sum += s_meas[i];
              if (s_skew[i] < mn) mn = s_skew[i];
              if (s_skew[i] > mx) mx = s_skew[i];
            end
            b1 = sum / NS;
            b5 = b1 ^ mn ^ mx;
            if (p > 0) ovr_m = 1;
            else begin
              exp_q.push_back(8'hA5); exp_q.push_back(8'(b1)); exp_q.push_back(8'(mn));
              exp_q.push_back(8'(mx)); exp_q.push_back(8'h00); exp_q.push_back(8'(b5));
              pend = 6;
            end
            s_meas.delete(); s_skew.delete();
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_on) begin
      check("overrun", ovr, ovr_m);
      check("tx_valid", ifa.tx_valid, pend > 0);
      if (ifa.tx_valid) begin
        if (exp_q.size() == 0) check("unexpected_byte", ifa.tx_data, 8'hxx);
        else begin
          check("tx_data", ifa.tx_data, exp_q[0]);
          if (ifa.tx_ready) begin
            rx_q.push_back(ifa.tx_data);
            void'(exp_q.pop_front());
          end
        end
      end else check("idle_data", ifa.tx_data, 0);
      if (ifb.tx_valid) begin
        if (exp_b.size() == 0) check("b_unexpected", ifb.tx_data, 8'hxx);
        else check("b_data", ifb.tx_data, exp_b.pop_front());
      end
    end
  end
  initial begin
    ifa.tx_ready = 0;
    ifb.tx_ready = 1;
    cyc(3);
    rst = 0;
    chk_on = 1;
    check("rst_busy", busy, 0);
    check("rst_valid", ifa.tx_valid, 0);
    // basic frame
    ifa.tx_ready = 1; en = 1; meas = 10; skew = 5;
    cyc(4);
    meas = 13; skew = 9;
    cyc(4);
    en = 0;
    cyc(1);
    check("busy_send", busy, 1);
    drain();
    cyc(1);
    check("busy_idle", busy, 0);
    check_rx("basic", 48'hA5_0B_05_09_00_07);
    // stalled consumer while acquisition overruns
    ifa.tx_ready = 0; en = 1; meas = 20; skew = 10;
    cyc(8);
    cyc(20);
    check("stall_data", ifa.tx_data, 8'hA5);
    check("stall_valid", ifa.tx_valid, 1);
    check("stall_overrun", ovr, 1);
    ifa.tx_ready = 1; en = 0;
    drain();
    check_rx("stall", 48'hA5_14_0A_0A_00_14);
    // reset while the third byte is pending
    ifa.tx_ready = 0; en = 1; meas = 8'($urandom); skew = 7'($urandom);
    cyc(8);
    ifa.tx_ready = 1;
    cyc(2);
    ifa.tx_ready = 0; rst = 1; en = 0;
    cyc(1);
    rst = 0;
    check("rstmid_valid", ifa.tx_valid, 0);
    check("rstmid_overrun", ovr, 0);
    check("rstmid_busy", busy, 0);
    rx_q.delete();
    // enable dropped after one sample, then fresh frame
    ifa.tx_ready = 1; en = 1; meas = 50; skew = 20;
    cyc(4);
    en = 0;
    cyc(1);
    check("drop_busy", busy, 0);
    cyc(10);
    en = 1; meas = 2; skew = 30;
    cyc(4);
    meas = 4; skew = 40;
    cyc(4);
    en = 0;
    drain();
    check_rx("fresh", 48'hA5_03_1E_28_00_35);
    // extremes
    en = 1; meas = 8'hFF; skew = 7'h7F;
    cyc(4);
    skew = 0;
    cyc(4);
    en = 0;
    drain();
    check_rx("extreme", 48'hA5_FF_00_7F_00_80);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      en = $urandom_range(0, 99) < 95;
      meas = 8'($urandom);
      skew = 7'($urandom);
      ifa.tx_ready = ($urandom % 4) != 0;
      cyc(1);
    end
    en = 0; ifa.tx_ready = 1;
    drain();
    check("queue_empty", exp_q.size(), 0);
    // saturating oscillator edge count on the long-interval instance
    exp_b = '{8'hA5, 8'h28, 8'h03, 8'h03, 8'hFF, 8'hD7};
    en_b = 1;
    for (int i = 0; i < 3000 && exp_b.size() > 0; i++) begin
      osc_b = ~osc_b;
      cyc(1);
    end
    en_b = 0;
    check("b_frame_done", exp_b.size(), 0);
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
